// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issues decoded multiplier instructions, tracks them through execute,
// drives Rn writeback, ASTAT MV/MN capture and sticky MOS, and stalls on I-stage RAW hazards.
module mul_issue_ctrl #(
  parameter int RF_DATASIZE = 16,
  parameter int RF_ADDSIZE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec_valid,
  input  logic [8+3*RF_ADDSIZE:0] dec_ins,
  output logic                   dec_rdy,
  output logic                   ps_mul_en,
  output logic                   ps_mul_otreg,
  output logic [3:0]             ps_mul_dtsts,
  output logic [1:0]             ps_mul_cls,
  output logic [1:0]             ps_mul_sc,
  output logic [RF_ADDSIZE-1:0]  ps_xb_rdx_add,
  output logic [RF_ADDSIZE-1:0]  ps_xb_rdy_add,
  input  logic [RF_DATASIZE-1:0] mul_xb_dt,
  input  logic                   mul_ps_mv,
  input  logic                   mul_ps_mn,
  output logic                   ps_xb_wrt_en,
  output logic [RF_ADDSIZE-1:0]  ps_xb_wrt_add,
  output logic [RF_DATASIZE-1:0] ps_xb_wrt_dt,
  input  logic                   ps_stky_clr,
  output logic                   ps_astat_mv,
  output logic                   ps_astat_mn,
  output logic                   ps_stky_mos
);
  localparam int A = RF_ADDSIZE;
  logic [1:0] d_cls, d_sc;
  logic d_ot;
  logic [3:0] d_dts;
  logic [A-1:0] d_rn, d_rx, d_ry;
  logic uses_rx, uses_ry, hazard, accept, flag_op;
  logic en_q, en_d, ot_q, ot_d;
  logic [3:0] dts_q, dts_d;
  logic [1:0] cls_q, cls_d, sc_q, sc_d;
  logic [A-1:0] rdx_q, rdx_d, rdy_q, rdy_d, rn_q, rn_d;
  logic e_valid_q, e_ot_q;
  logic [1:0] e_cls_q, e_sc_q;
  logic [A-1:0] e_rn_q;
  logic mv_q, mv_d, mn_q, mn_d, mos_q, mos_d;
  assign {d_cls, d_sc, d_ot, d_dts, d_rn, d_rx, d_ry} = dec_ins;
  assign uses_ry = d_cls != 2'b00;
  assign uses_rx = ~(d_cls == 2'b00 && (~d_ot || d_sc == 2'b11));
  // Only the I-stage write can collide; an E-stage write lands before the next read.
  assign hazard  = en_q & ~ot_q & ((uses_rx & (d_rx == rn_q)) | (uses_ry & (d_ry == rn_q)));
  assign dec_rdy = ~hazard;
  assign accept  = dec_valid & ~hazard;
  assign flag_op = e_valid_q & ~(e_cls_q == 2'b00 && e_sc_q != 2'b11);
  always_comb begin
    en_d  = accept;
    ot_d  = accept ? d_ot  : ot_q;
    dts_d = accept ? d_dts : dts_q;
    cls_d = accept ? d_cls : cls_q;
    sc_d  = accept ? d_sc  : sc_q;
    rdx_d = accept ? d_rx  : rdx_q;
    rdy_d = accept ? d_ry  : rdy_q;
    rn_d  = accept ? d_rn  : rn_q;
    mv_d  = flag_op ? mul_ps_mv : mv_q;
    mn_d  = flag_op ? mul_ps_mn : mn_q;
    mos_d = (flag_op & mul_ps_mv) ? 1'b1 : ps_stky_clr ? 1'b0 : mos_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      ot_q      <= 1'b0;
      dts_q     <= '0;
      cls_q     <= '0;
      sc_q      <= '0;
      rdx_q     <= '0;
      rdy_q     <= '0;
      rn_q      <= '0;
      e_valid_q <= 1'b0;
      e_ot_q    <= 1'b0;
      e_cls_q   <= '0;
      e_sc_q    <= '0;
      e_rn_q    <= '0;
      mv_q      <= 1'b0;
      mn_q      <= 1'b0;
      mos_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      ot_q      <= ot_d;
      dts_q     <= dts_d;
      cls_q     <= cls_d;
      sc_q      <= sc_d;
      rdx_q     <= rdx_d;
      rdy_q     <= rdy_d;
      rn_q      <= rn_d;
      e_valid_q <= en_q;
      e_ot_q    <= ot_q;
      e_cls_q   <= cls_q;
      e_sc_q    <= sc_q;
      e_rn_q    <= rn_q;
      mv_q      <= mv_d;
      mn_q      <= mn_d;
      mos_q     <= mos_d;
    end
  end
  assign ps_mul_en     = en_q;
  assign ps_mul_otreg  = ot_q;
  assign ps_mul_dtsts  = dts_q;
  assign ps_mul_cls    = cls_q;
  assign ps_mul_sc     = sc_q;
  assign ps_xb_rdx_add = rdx_q;
  assign ps_xb_rdy_add = rdy_q;
  // Reset discards the instruction in E, so its write must not reach the register file.
  assign ps_xb_wrt_en  = e_valid_q & ~e_ot_q & ~reset;
  assign ps_xb_wrt_add = e_rn_q;
  assign ps_xb_wrt_dt  = mul_xb_dt;
  assign ps_astat_mv   = mv_q;
  assign ps_astat_mn   = mn_q;
  assign ps_stky_mos   = mos_q;
endmodule
